// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control/status bundle between the PC control unit and pc_sequencer
// master: PC control side, drives the redirect controls and observes pc/fetch status
// slave:  pc_sequencer side
interface pc_sequencer_if #(parameter int PC_W = 16);
  logic            stall;
  logic            halt;
  logic [1:0]      pcSrc;
  logic            call;
  logic            ret;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] jr_target;
  logic [PC_W-1:0] ret_addr;
  logic [PC_W-1:0] pc;
  logic            fetch_valid;
  logic [PC_W-1:0] ras_top;
  logic            ras_underflow;
  logic            src_err;
  logic [15:0]     redirect_cnt;
  modport master (
    output stall, halt, pcSrc, call, ret, br_target, jr_target, ret_addr,
    input  pc, fetch_valid, ras_top, ras_underflow, src_err, redirect_cnt
  );
  modport slave (
    input  stall, halt, pcSrc, call, ret, br_target, jr_target, ret_addr,
    output pc, fetch_valid, ras_top, ras_underflow, src_err, redirect_cnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC owner with BOOT/RUN/HALTED sequencing, redirect counter and optional RAS
// ports: clk, rst_n (sync, active-low), bus (pc_sequencer_if.slave: stall/halt/pcSrc/call/ret/
//        br_target/jr_target/ret_addr in; pc/fetch_valid/ras_top/ras_underflow/src_err/redirect_cnt out)
// PC_SEQ_RAS_EN: when defined, the return-address stack is built; otherwise ras_top/ras_underflow are 0
module pc_sequencer #(
  parameter int              PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_sequencer_if.slave   bus
);
  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            src_err_q, src_err_d;
  logic [15:0]     redirect_cnt_q, redirect_cnt_d;
  logic            run, redir;
  always_comb begin
    run            = state_q == RUN;
    redir          = bus.pcSrc == 2'b01 || bus.pcSrc == 2'b10;
    state_d        = state_q == BOOT ? RUN : (run && bus.halt) ? HALTED : state_q;
    // redirect beats stall; pcSrc=11 falls through to the stall/PC+1 choice
    pc_d           = (!run || bus.halt)      ? pc_q :
                     bus.pcSrc == 2'b01      ? bus.br_target :
                     bus.pcSrc == 2'b10      ? bus.jr_target :
                     bus.stall               ? pc_q : pc_q + 1'b1;
    fetch_valid_d  = state_d == RUN;
    src_err_d      = bus.pcSrc == 2'b11;
    redirect_cnt_d = (run && !bus.halt && redir && redirect_cnt_q != 16'hFFFF) ? redirect_cnt_q + 16'd1
                                                                                : redirect_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= BOOT;
      pc_q           <= RESET_PC;
      fetch_valid_q  <= 1'b0;
      src_err_q      <= 1'b0;
      redirect_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      fetch_valid_q  <= fetch_valid_d;
      src_err_q      <= src_err_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end
  assign bus.pc           = pc_q;
  assign bus.fetch_valid  = fetch_valid_q;
  assign bus.src_err      = src_err_q;
  assign bus.redirect_cnt = redirect_cnt_q;
`ifdef PC_SEQ_RAS_EN
  localparam int            AW       = $clog2(RAS_DEPTH);
  localparam logic [AW:0]   RAS_FULL = (AW+1)'(RAS_DEPTH);
  // circular buffer: sp points at the top entry, so a push when full lands on the oldest slot
  logic [RAS_DEPTH-1:0][PC_W-1:0] ras_q, ras_d;
  logic [AW-1:0]                  sp_q, sp_d;
  logic [AW:0]                    ras_cnt_q, ras_cnt_d;
  logic                           ras_underflow_q, ras_underflow_d;
  logic                           push, pop, empty;
  always_comb begin
    push            = run && bus.pcSrc == 2'b01 && bus.call;
    pop             = run && bus.pcSrc == 2'b10 && bus.ret;
    empty           = ras_cnt_q == '0;
    ras_d           = ras_q;
    sp_d            = sp_q;
    ras_cnt_d       = ras_cnt_q;
    ras_underflow_d = ras_underflow_q;
    if (push && (!pop || empty)) begin
      sp_d        = sp_q + 1'b1;
      ras_d[sp_d] = bus.ret_addr;
      ras_cnt_d   = ras_cnt_q == RAS_FULL ? ras_cnt_q : ras_cnt_q + 1'b1;
    end else if (push) begin
      ras_d[sp_q] = bus.ret_addr;
    end else if (pop && empty) begin
      ras_underflow_d = 1'b1;
    end else if (pop) begin
      sp_d      = sp_q - 1'b1;
      ras_cnt_d = ras_cnt_q - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ras_q           <= '0;
      sp_q            <= '0;
      ras_cnt_q       <= '0;
      ras_underflow_q <= 1'b0;
    end else begin
      ras_q           <= ras_d;
      sp_q            <= sp_d;
      ras_cnt_q       <= ras_cnt_d;
      ras_underflow_q <= ras_underflow_d;
    end
  end
  assign bus.ras_top       = empty ? '0 : ras_q[sp_q];
  assign bus.ras_underflow = ras_underflow_q;
`else
  logic unused_ras;
  assign unused_ras        = ^{bus.call, bus.ret, bus.ret_addr, RAS_DEPTH[0]};
  assign bus.ras_top       = '0;
  assign bus.ras_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized and directed checks of pc_sequencer against a queue-based reference model
module tb_pc_sequencer;
  localparam int DEPTH = 4;
`ifdef PC_SEQ_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pc_sequencer_if #(.PC_W(16)) bus ();
  pc_sequencer #(.PC_W(16), .RESET_PC(16'h0000), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  int n_vec = 0;
  int n_err = 0;
  // reference model: plain booleans and a queue for the return stack
  logic [15:0] m_pc;
  bit          m_booted, m_halted, m_valid, m_uf, m_err;
  int          m_cnt;
  logic [15:0] m_ras[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_edge();
    if (!rst_n) begin
      m_pc = 16'h0; m_booted = 0; m_halted = 0; m_valid = 0; m_uf = 0; m_err = 0; m_cnt = 0;
      m_ras.delete();
      return;
    end
    m_err = bus.pcSrc == 2'b11;
    if (!m_booted) begin
      m_booted = 1; m_valid = 1;
    end else if (!m_halted) begin
      if (RAS_EN && bus.pcSrc == 2'b01 && bus.call) begin
        m_ras.push_back(bus.ret_addr);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
      if (RAS_EN && bus.pcSrc == 2'b10 && bus.ret) begin
        if (m_ras.size() == 0) m_uf = 1;
        else void'(m_ras.pop_back());
      end
      if (!bus.halt && (bus.pcSrc == 2'b01 || bus.pcSrc == 2'b10) && m_cnt < 65535) m_cnt++;
      if (bus.halt) begin
        m_halted = 1; m_valid = 0;
      end else if (bus.pcSrc == 2'b01) m_pc = bus.br_target;
      else if (bus.pcSrc == 2'b10) m_pc = bus.jr_target;
      else if (!bus.stall) m_pc = m_pc + 16'd1;
    end
  endtask
  task automatic cyc(input logic s, input logic h, input logic [1:0] src, input logic c, input logic r,
                     input logic [15:0] br, input logic [15:0] jr, input logic [15:0] ra);
    bus.stall = s; bus.halt = h; bus.pcSrc = src; bus.call = c; bus.ret = r;
    bus.br_target = br; bus.jr_target = jr; bus.ret_addr = ra;
    @(posedge clk);
    model_edge();
    #1;
    check("pc", bus.pc, m_pc);
    check("fetch_valid", bus.fetch_valid, m_valid);
    check("ras_top", bus.ras_top, m_ras.size() == 0 ? 16'h0 : m_ras[$]);
    check("ras_underflow", bus.ras_underflow, m_uf);
    check("src_err", bus.src_err, m_err);
    check("redirect_cnt", bus.redirect_cnt, m_cnt);
  endtask
  task automatic idle(); cyc(0, 0, 2'b00, 0, 0, 16'h0, 16'h0, 16'h0); endtask
  initial begin
    rst_n = 0;
    idle(); idle();
    check("rst_pc", bus.pc, 16'h0);
    check("rst_valid", bus.fetch_valid, 0);
    rst_n = 1;
    idle();
    check("boot_valid", bus.fetch_valid, 1);
    check("boot_pc", bus.pc, 16'h0);
    idle(); idle(); idle();
    check("seq_pc3", bus.pc, 16'h3);
    idle(); idle();
    check("pc5", bus.pc, 16'h5);
    cyc(1, 0, 2'b01, 0, 0, 16'h40, 16'h0, 16'h0);
    check("redir_over_stall", bus.pc, 16'h40);
    check("redir_cnt1", bus.redirect_cnt, 1);
    cyc(0, 0, 2'b01, 1, 0, 16'h80, 16'h0, 16'h11);
    check("call_top", bus.ras_top, RAS_EN ? 16'h11 : 16'h0);
    cyc(0, 0, 2'b10, 0, 1, 16'h0, 16'h11, 16'h0);
    check("ret_pc", bus.pc, 16'h11);
    check("ret_top", bus.ras_top, 16'h0);
    check("ret_uf", bus.ras_underflow, 0);
    for (int i = 1; i <= 5; i++) cyc(0, 0, 2'b01, 1, 0, 16'h100, 16'h0, 16'(i));
    for (int i = 5; i >= 1; i--) begin
      check("pop_top", bus.ras_top, (RAS_EN && i >= 2) ? 16'(i) : 16'h0);
      cyc(0, 0, 2'b10, 0, 1, 16'h0, 16'h200, 16'h0);
    end
    check("underflow", bus.ras_underflow, RAS_EN);
    cyc(0, 0, 2'b01, 0, 0, 16'h7, 16'h0, 16'h0);
    cyc(0, 0, 2'b11, 0, 0, 16'h0, 16'h0, 16'h0);
    check("src11_pc", bus.pc, 16'h8);
    check("src11_err", bus.src_err, 1);
    idle();
    check("src11_err_clr", bus.src_err, 0);
    cyc(0, 0, 2'b01, 0, 0, 16'hFFFF, 16'h0, 16'h0);
    idle();
    check("wrap_pc", bus.pc, 16'h0);
    cyc(0, 0, 2'b10, 0, 0, 16'h0, 16'h20, 16'h0);
    cyc(0, 1, 2'b00, 0, 0, 16'h0, 16'h0, 16'h0);
    check("halt_pc", bus.pc, 16'h20);
    check("halt_valid", bus.fetch_valid, 0);
    cyc(0, 0, 2'b01, 1, 0, 16'h99, 16'h0, 16'h33);
    cyc(0, 0, 2'b10, 0, 1, 16'h0, 16'h55, 16'h0);
    check("halted_pc", bus.pc, 16'h20);
    rst_n = 0;
    cyc(0, 0, 2'b01, 1, 0, 16'h77, 16'h0, 16'h44);
    check("mid_rst_pc", bus.pc, 16'h0);
    check("mid_rst_cnt", bus.redirect_cnt, 0);
    rst_n = 1;
    for (int i = 0; i < 2000; i++) begin
      rst_n = $urandom_range(0, 149) != 0;
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 79) == 0, 2'($urandom_range(0, 3)),
          1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
